// File: rtl/enc_pkg.sv
// enc_pkg: widths, S1 bundle and key-to-mask expansion shared by the
// scheme-1 encryptor and decryptor (encryptor option: ENC_KEY_OVERRIDE_EN).
package enc_pkg;

  localparam int FRAME_W = 78;
  localparam int PLAIN_W = 60;
  localparam int KEY_W   = 11;
  localparam int TAG_W   = 6;
  localparam int Y_W     = 61;

  typedef struct packed {
    logic [PLAIN_W-1:0] plain;
    logic [KEY_W-1:0]   key;
  } s1_t;

  // 60-bit mask: five 11-bit key fields (some inverted) plus k[4:0] on top
  function automatic logic [PLAIN_W-1:0] mask_f(
    input logic [KEY_W-1:0] k
  );
    return {k[4:0], ~k, k, ~k, ~k, k};
  endfunction

endpackage

// File: rtl/enc_key_lfsr.sv
// enc_key_lfsr: 11-bit Fibonacci key LFSR (x^11+x^9+1), steps only on
// request; a zero seed is replaced by 1 and a zero state is forced out.
module enc_key_lfsr
  import enc_pkg::*;
#(
  parameter logic [KEY_W-1:0] SEED = 11'h5A3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             step,
  output logic [KEY_W-1:0] key
);

  localparam logic [KEY_W-1:0] ONE = {{(KEY_W-1){1'b0}}, 1'b1};
  localparam logic [KEY_W-1:0] SEED_EFF = (SEED == '0) ? ONE : SEED;

  logic [KEY_W-1:0] q;

  // shift left with feedback q[10]^q[8]; never parks at zero
  always_ff @(posedge Clk) begin
    if (Rst) begin
      q <= SEED_EFF;
    end else if (q == '0) begin
      q <= ONE;
    end else if (step) begin
      q <= {q[KEY_W-2:0], q[10] ^ q[8]};
    end
  end

  assign key = q;

endmodule

// File: rtl/encrypt_function_1.sv
// encrypt_function_1: two-stage valid/ready encryptor, frame = {y, key, tag}.
// Optional key override ports enabled by defining ENC_KEY_OVERRIDE_EN.
module encrypt_function_1
  import enc_pkg::*;
#(
  parameter logic [KEY_W-1:0] LFSR_SEED = 11'h5A3,
  parameter logic [TAG_W-1:0] FUNC_TAG  = 6'd1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PLAIN_W-1:0] plain,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FRAME_W-1:0] frame
`ifdef ENC_KEY_OVERRIDE_EN
  ,
  input  logic               key_ovr_en,
  input  logic [KEY_W-1:0]   key_ovr
`endif
);

  logic             accept;
  logic             s1_valid;
  logic             s1_load;
  logic             s2_load;
  logic [KEY_W-1:0] lfsr_key;
  logic [KEY_W-1:0] key_sel;
  s1_t              s1;
  logic [PLAIN_W-1:0] s1_mask;
  logic [Y_W-1:0]     s1_sum;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !Rst && s1_load;
  assign accept   = in_valid && in_ready;

`ifdef ENC_KEY_OVERRIDE_EN
  assign key_sel = key_ovr_en ? key_ovr : lfsr_key;
`else
  assign key_sel = lfsr_key;
`endif

  enc_key_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .Clk (Clk),
    .Rst (Rst),
    .step(accept),
    .key (lfsr_key)
  );

  assign s1_mask = mask_f(s1.key);
  assign s1_sum  = {s1.plain, 1'b0} + {1'b0, s1_mask};

  // S1: capture plaintext and key whenever the slot is free or draining
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1.plain <= plain;
        s1.key   <= key_sel;
      end
    end
  end

  // S2: register the sum; frame holds while stalled or empty
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_valid <= 1'b0;
      frame     <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        frame <= {s1_sum, s1.key, FUNC_TAG};
      end
    end
  end

endmodule

// File: tb/tb_encrypt_function_1.sv
// tb_encrypt_function_1: table vectors and random streams against a
// behavioural model of the scheme-1 encryptor (default build).
module tb_encrypt_function_1;

  localparam int NTV = 8;
  localparam int NSEQ = 2047;
  localparam logic [10:0] SEED = 11'h5A3;

  typedef struct {
    logic [59:0] plain;
    logic [10:0] key;
    logic [77:0] fr;
  } vec_t;

  typedef struct {
    logic [59:0] p;
    logic [77:0] fr;
    int          c;
  } sb_t;

  vec_t tv [NTV];

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic        Rst, in_valid, in_ready, out_valid, out_ready;
  logic [59:0] plain;
  logic [77:0] frame;
  logic        Rst0, iv0, ir0, ov0, or0;
  logic [59:0] pl0;
  logic [77:0] fr0;

  int errs = 0;
  int checks = 0;
  bit chk_lat = 0;
  bit chk_bp = 0;
  bit done = 0;
  bit fin = 0;

  encrypt_function_1 dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready), .plain(plain),
    .out_valid(out_valid), .out_ready(out_ready), .frame(frame)
  );

  encrypt_function_1 #(.LFSR_SEED(11'h000)) dut0 (
    .Clk(Clk), .Rst(Rst0),
    .in_valid(iv0), .in_ready(ir0), .plain(pl0),
    .out_valid(ov0), .out_ready(or0), .frame(fr0)
  );

  function automatic logic [59:0] ref_mask(input logic [10:0] k);
    logic [59:0] m;
    logic [4:0] inv;
    inv = 5'b10110;
    m = '0;
    for (int f = 0; f < 5; f++)
      m[f*11 +: 11] = inv[f] ? ~k : k;
    m[59:55] = k[4:0];
    return m;
  endfunction

  function automatic logic [77:0] ref_frame(
    input logic [59:0] p, input logic [10:0] k);
    logic [63:0] x, m, y;
    x = {3'b0, p, 1'b0};
    m = {4'b0, ref_mask(k)};
    y = (x + m) % (64'd1 << 61);
    return {y[60:0], k, 6'd1};
  endfunction

  function automatic logic [60:0] ref_dec(input logic [77:0] f);
    logic [63:0] y, m, d;
    y = {3'b0, f[77:17]};
    m = {4'b0, ref_mask(f[16:6])};
    d = (y + (64'd1 << 61) - m) % (64'd1 << 61);
    return d[60:0];
  endfunction

  function automatic logic [10:0] lfsr_next(input logic [10:0] q);
    int v;
    v = int'(q);
    return 11'(((v * 2) % 2048) + (((v >> 10) ^ (v >> 8)) & 1));
  endfunction

  function automatic logic [59:0] rnd60();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[59:0];
  endfunction

  task automatic chk(input string nm, input logic [77:0] act,
                     input logic [77:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // scoreboard / protocol monitor for both instances, sampled mid-cycle
  always @(negedge Clk) begin : mon
    static sb_t q[$];
    static logic [59:0] p0_q[$];
    static logic [10:0] k0_q[$];
    static bit seen [2048];
    static logic [10:0] mkey = SEED;
    static logic [10:0] mkey0 = 11'h001;
    static bit rst_prev = 0;
    static bit stalled = 0;
    static bit first = 1;
    static int stall_cnt = 0;
    static int n0 = 0;
    static logic [77:0] held = '0;
    sb_t e;
    logic [59:0] p;
    logic [10:0] k;

    if (Rst) begin
      chk("rst_in_ready", 78'(in_ready), 78'd0);
      q.delete();
      mkey = SEED;
      stalled = 0;
      stall_cnt = 0;
      first = 1;
    end else begin
      if (rst_prev) begin
        chk("rst_out_valid", 78'(out_valid), 78'd0);
        chk("rst_frame", frame, 78'd0);
      end
      if (stalled)
        chk("hold", {out_valid, frame[76:0]}, {1'b1, held[76:0]});
      if (chk_bp && out_valid && !out_ready) begin
        stall_cnt++;
        if (stall_cnt >= 3)
          chk("stall_in_ready", 78'(in_ready), 78'd0);
      end else begin
        stall_cnt = 0;
      end
      if (chk_lat)
        chk("throughput_in_ready", 78'(in_ready), 78'd1);
      if (in_valid && in_ready) begin
        e.p = plain;
        e.fr = ref_frame(plain, mkey);
        e.c = cyc;
        q.push_back(e);
        mkey = lfsr_next(mkey);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_frame", 78'd1, 78'd0);
        end else begin
          e = q.pop_front();
          chk("frame", frame, e.fr);
          chk("roundtrip", 78'(ref_dec(frame)), 78'({e.p, 1'b0}));
          if (chk_lat)
            chk("latency", 78'(cyc - e.c), 78'd2);
          if (first) begin
            chk("key_after_reset", 78'(frame[16:6]), 78'(SEED));
            first = 0;
          end
        end
      end
      stalled = out_valid && !out_ready;
      held = frame;
    end
    rst_prev = Rst;

    if (Rst0) begin
      p0_q.delete();
      k0_q.delete();
      mkey0 = 11'h001;
      n0 = 0;
      foreach (seen[i]) seen[i] = 0;
    end else begin
      if (iv0 && ir0) begin
        p0_q.push_back(pl0);
        k0_q.push_back(mkey0);
        mkey0 = lfsr_next(mkey0);
      end
      if (ov0 && or0) begin
        if (p0_q.size() == 0) begin
          chk("extra_frame0", 78'd1, 78'd0);
        end else begin
          p = p0_q.pop_front();
          k = k0_q.pop_front();
          chk("frame0", fr0, ref_frame(p, k));
          if (n0 < NTV)
            chk("table", fr0, tv[n0].fr);
          chk("key_distinct",
              78'(fr0[16:6] == 11'd0 || seen[fr0[16:6]]), 78'd0);
          seen[fr0[16:6]] = 1;
          chk("roundtrip0", 78'(ref_dec(fr0)), 78'({p, 1'b0}));
          if (p == {60{1'b1}} && k == 11'h7FF)
            chk("wrap", 78'(fr0[77:17] < {p, 1'b0}), 78'd1);
          n0++;
        end
      end
    end

    if (done && !fin) begin
      chk("drain_main", 78'(q.size()), 78'd0);
      chk("drain0", 78'(p0_q.size()), 78'd0);
      chk("count0", 78'(n0), 78'(NSEQ));
      fin = 1;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send();
    int g;
    g = 0;
    #1;
    while (!in_ready && g < 50) begin
      step();
      g++;
    end
    step();
  endtask

  task automatic send0();
    int g;
    g = 0;
    #1;
    while (!ir0 && g < 50) begin
      step();
      g++;
    end
    step();
  endtask

  initial begin
    logic [10:0] kd;
    int sent;
    bit acc;

    kd = 11'h001;
    for (int i = 0; i < NTV; i++) begin
      tv[i].key = kd;
      case (i)
        0: tv[i].plain = '0;
        1: tv[i].plain = {60{1'b1}};
        2: tv[i].plain = 60'h800_0000_0000_0000;
        default: tv[i].plain = rnd60();
      endcase
      if (i == 0)
        tv[i].fr = {1'b0, ref_mask(11'h001), 11'h001, 6'd1};
      else
        tv[i].fr = ref_frame(tv[i].plain, kd);
      kd = lfsr_next(kd);
    end

    Rst = 1; Rst0 = 1;
    in_valid = 0; iv0 = 0;
    out_ready = 1; or0 = 1;
    plain = '0; pl0 = '0;
    repeat (3) step();
    Rst = 0; Rst0 = 0;

    for (int i = 0; i < NTV; i++) begin
      pl0 = tv[i].plain;
      iv0 = 1;
      send0();
      iv0 = 0;
      repeat (3) step();
    end
    for (int j = 0; j < NSEQ - NTV; j++) begin
      pl0 = (kd == 11'h7FF) ? {60{1'b1}} : rnd60();
      iv0 = 1;
      send0();
      kd = lfsr_next(kd);
    end
    iv0 = 0;
    repeat (5) step();

    chk_lat = 1;
    in_valid = 1;
    for (int j = 0; j < 1000; j++) begin
      plain = rnd60();
      send();
    end
    in_valid = 0;
    repeat (5) step();
    chk_lat = 0;

    chk_bp = 1;
    sent = 0;
    plain = rnd60();
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 8 && c < 13);
      in_valid = (sent < 20);
      #1;
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        sent++;
        plain = rnd60();
      end
    end
    in_valid = 0;
    out_ready = 1;
    repeat (5) step();
    chk_bp = 0;

    in_valid = 1;
    plain = rnd60();
    send();
    plain = rnd60();
    send();
    in_valid = 0;
    Rst = 1;
    step();
    Rst = 0;
    step();
    plain = rnd60();
    in_valid = 1;
    send();
    in_valid = 0;
    repeat (5) step();

    done = 1;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
